// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small byte FIFO feeding an 8N1 UART serialiser; tx_en freezes the serialiser
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       wr_en,
    input  logic [7:0] wr_dat,
    output logic       full,
    output logic       empty,
    output logic       ovf,
    output logic       tx,
    output logic       busy,
    output logic       utdone
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state;
    logic [7:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0] count;
    logic [BW-1:0] baud_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic pop, push, bit_end;
    assign full    = count[FIFO_AW];
    assign empty   = count == '0;
    assign pop     = tx_en && state == IDLE && !empty;
    assign push    = wr_en && (!full || pop);
    assign bit_end = baud_cnt == BW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
            if (wr_en && !push) ovf <= 1'b1;
        end
    end
    // Every state change waits for tx_en, so a low tx_en simply stretches the current bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            utdone   <= 1'b0;
        end else begin
            utdone <= 1'b0;
            if (tx_en) begin
                baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
                case (state)
                    IDLE: if (!empty) begin
                        shift <= mem[rd_ptr];
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                    START: if (bit_end) begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                    DATA: if (bit_end) begin
                        tx      <= bit_idx == 3'd7 ? 1'b1 : shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        state   <= bit_idx == 3'd7 ? STOP : DATA;
                    end
                    STOP: if (bit_end) begin
                        busy   <= 1'b0;
                        utdone <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized scenarios checked against an independent line decoder and byte-queue model
module tb_uart_tx_fifo;
    localparam int C = 4;
    logic clk = 1'b0, rst = 1'b0, tx_en = 1'b0, wr_en = 1'b0;
    logic [7:0] wr_dat = '0;
    logic full, empty, ovf, tx, busy, utdone;
    int total = 0, bad = 0;
    int cyc = 0, done_cnt = 0, overlap = 0, glitch = 0, frame_err = 0, en_cnt = 0;
    logic in_frame = 1'b0, prev_tx = 1'b1, cur = 1'b1;
    logic [7:0] rx_byte = '0;
    logic [7:0] rx_q[$];
    int start_q[$];

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_AW(2)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .wr_en(wr_en), .wr_dat(wr_dat),
        .full(full), .empty(empty), .ovf(ovf), .tx(tx), .busy(busy), .utdone(utdone)
    );

    always #5 clk = ~clk;

    // Line decoder: counts only enabled edges per bit, so frozen cycles stretch bits without breaking framing.
    always @(negedge clk) begin
        cyc++;
        if (utdone) done_cnt++;
        if (utdone && busy) overlap++;
        if (rst) in_frame = 1'b0;
        else if (!in_frame && prev_tx && tx === 1'b0) begin
            in_frame = 1'b1;
            en_cnt = 0;
            start_q.push_back(cyc);
        end
        if (!rst && in_frame) begin
            if (tx_en && en_cnt % C == 0) cur = tx;
            else if (tx !== cur) glitch++;
            if (tx_en) begin
                if (en_cnt == 0 && tx !== 1'b0) frame_err++;
                if (en_cnt == 9 * C && tx !== 1'b1) frame_err++;
                if (en_cnt % C == 0 && en_cnt >= C && en_cnt < 9 * C) rx_byte[en_cnt / C - 1] = tx;
                en_cnt++;
                if (en_cnt == 10 * C) begin
                    in_frame = 1'b0;
                    rx_q.push_back(rx_byte);
                end
            end
        end
        prev_tx = tx;
    end

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        return j == 0 ? 1'b0 : j == 9 ? 1'b1 : b[j - 1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_dat = b;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        rx_q.delete();
        start_q.delete();
    endtask

    task automatic wait_done(input int target, input int budget, output bit to);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        to = done_cnt < target;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (utdone !== 1'b0) begin bad++; $display("FAIL reset_utdone got=%b exp=0", utdone); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        repeat (2) tick();
        rst = 1'b0;
        tx_en = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int d0 = done_cnt;
        logic [7:0] b = 8'hA5;
        rx_q.delete();
        push(b);
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", empty); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_tx_pre got=%b exp=1", tx); end
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        for (int i = 0; i < 10 * C; i++) begin
            total++;
            if (tx !== frame_bit(b, i / C)) begin
                bad++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", i, tx, frame_bit(b, i / C));
            end
            tick();
        end
        total++; if (utdone !== 1'b1) begin bad++; $display("FAIL single_utdone got=%b exp=1", utdone); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        tick();
        total++; if (utdone !== 1'b0) begin bad++; $display("FAIL single_utdone_pulse got=%b exp=0", utdone); end
        repeat (5) tick();
        total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=%0d", done_cnt, d0 + 1); end
        total++; if (rx_q.size() != 1 || rx_q[0] !== b) begin bad++; $display("FAIL single_rx got_n=%0d exp=a5", rx_q.size()); end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        bit to;
        rx_q.delete();
        start_q.delete();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_done(d0 + 3, 3 * (10 * C + 1) + 20, to);
        total++; if (to) begin bad++; $display("FAIL b2b_timeout got=%0d exp=%0d", done_cnt, d0 + 3); end
        total++; if (start_q.size() != 3) begin bad++; $display("FAIL b2b_starts got=%0d exp=3", start_q.size()); end
        for (int i = 1; i < 3 && i < start_q.size(); i++) begin
            total++;
            if (start_q[i] - start_q[i - 1] != 10 * C + 1) begin
                bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", start_q[i] - start_q[i - 1], 10 * C + 1);
            end
        end
        total++; if (rx_q.size() != 3) begin bad++; $display("FAIL b2b_rx_n got=%0d exp=3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== 8'(i + 1)) begin bad++; $display("FAIL b2b_rx got=%h exp=%h", rx_q[i], 8'(i + 1)); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    task automatic test_rst_mid_frame();
        int d0;
        tx_en = 1'b0;
        repeat (5) push(8'($urandom));
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL rstmid_pre_ovf got=%b exp=1", ovf); end
        tx_en = 1'b1;
        repeat (15) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre_busy got=%b exp=1", busy); end
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rstmid_ovf got=%b exp=0", ovf); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rstmid_full got=%b exp=0", full); end
        tick();
        rst = 1'b0;
        rx_q.delete();
        repeat (60) tick();
        total++; if (done_cnt != d0) begin bad++; $display("FAIL rstmid_utdone got=%0d exp=%0d", done_cnt, d0); end
        total++; if (rx_q.size() != 0) begin bad++; $display("FAIL rstmid_rx got=%0d exp=0", rx_q.size()); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx_idle got=%b exp=1", tx); end
    endtask

    task automatic test_overflow();
        logic [7:0] b[5];
        int d0;
        bit to;
        do_reset();
        tx_en = 1'b0;
        foreach (b[i]) b[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            push(b[i]);
            if (i == 3) begin
                total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full4 got=%b exp=1", full); end
                total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf); end
            end
        end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        repeat (10) tick();
        total++; if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b0) begin
            bad++; $display("FAIL ovf_frozen got tx=%b busy=%b empty=%b exp 1 0 0", tx, busy, empty);
        end
        d0 = done_cnt;
        tx_en = 1'b1;
        wait_done(d0 + 4, 4 * (10 * C + 1) + 20, to);
        total++; if (to) begin bad++; $display("FAIL ovf_timeout got=%0d exp=%0d", done_cnt, d0 + 4); end
        repeat (60) tick();
        total++; if (done_cnt != d0 + 4) begin bad++; $display("FAIL ovf_frames got=%0d exp=%0d", done_cnt - d0, 4); end
        total++; if (rx_q.size() != 4) begin bad++; $display("FAIL ovf_rx_n got=%0d exp=4", rx_q.size()); end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== b[i]) begin bad++; $display("FAIL ovf_rx got=%h exp=%h", rx_q[i], b[i]); end
        end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    endtask

    task automatic test_push_on_pop();
        logic [7:0] b[5];
        int d0;
        bit to;
        do_reset();
        tx_en = 1'b0;
        foreach (b[i]) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) push(b[i]);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL pop_pre_full got=%b exp=1", full); end
        d0 = done_cnt;
        tx_en = 1'b1;
        push(b[4]);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL pop_full got=%b exp=1", full); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL pop_ovf got=%b exp=0", ovf); end
        wait_done(d0 + 5, 5 * (10 * C + 1) + 20, to);
        total++; if (to) begin bad++; $display("FAIL pop_timeout got=%0d exp=%0d", done_cnt, d0 + 5); end
        total++; if (rx_q.size() != 5) begin bad++; $display("FAIL pop_rx_n got=%0d exp=5", rx_q.size()); end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== b[i]) begin bad++; $display("FAIL pop_rx got=%h exp=%h", rx_q[i], b[i]); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL pop_empty got=%b exp=1", empty); end
    endtask

    task automatic test_freeze();
        logic [7:0] bytes[2];
        bytes[0] = 8'hFF;
        bytes[1] = 8'($urandom);
        for (int k = 0; k < 2; k++) begin
            repeat (3) tick();
            rx_q.delete();
            push(bytes[k]);
            tick();
            for (int i = 0; i < 10 * C + 7; i++) begin
                int j = i < 4 * C ? i / C : i < 5 * C + 7 ? 4 : (i - 7) / C;
                total++;
                if (tx !== frame_bit(bytes[k], j)) begin
                    bad++; $display("FAIL freeze_tx byte=%h cyc=%0d got=%b exp=%b", bytes[k], i, tx, frame_bit(bytes[k], j));
                end
                if (i == 4 * C + 1) tx_en = 1'b0;
                if (i == 4 * C + 8) tx_en = 1'b1;
                tick();
            end
            total++; if (utdone !== 1'b1) begin bad++; $display("FAIL freeze_utdone got=%b exp=1", utdone); end
            tick();
            total++; if (rx_q.size() != 1 || rx_q[0] !== bytes[k]) begin bad++; $display("FAIL freeze_rx exp=%h n=%0d", bytes[k], rx_q.size()); end
        end
    endtask

    task automatic test_random_stream();
        for (int r = 0; r < 3; r++) begin
            logic [7:0] exp_q[$];
            int d0 = done_cnt;
            bit to;
            rx_q.delete();
            for (int i = 0; i < 5; i++) begin
                logic [7:0] b = 8'($urandom);
                exp_q.push_back(b);
                push(b);
                repeat ($urandom_range(0, 20)) tick();
            end
            wait_done(d0 + 5, 5 * (10 * C + 1) + 20, to);
            total++; if (to) begin bad++; $display("FAIL rand_timeout got=%0d exp=%0d", done_cnt, d0 + 5); end
            total++; if (rx_q.size() != 5) begin bad++; $display("FAIL rand_rx_n got=%0d exp=5", rx_q.size()); end
            for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
                total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_rx got=%h exp=%h", rx_q[i], exp_q[i]); end
            end
            total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rand_ovf got=%b exp=0", ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_rst_mid_frame();
        test_overflow();
        test_push_on_pop();
        test_freeze();
        test_random_stream();
        total++; if (overlap != 0) begin bad++; $display("FAIL utdone_busy_overlap got=%0d exp=0", overlap); end
        total++; if (glitch != 0) begin bad++; $display("FAIL tx_glitch got=%0d exp=0", glitch); end
        total++; if (frame_err != 0) begin bad++; $display("FAIL framing got=%0d exp=0", frame_err); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
